// File: rtl/cntr_tick_gen.sv
// cntr_tick_gen: enable-pulse sequencer for the downstream gate-level counter.
// It produces single-cycle en pulses at a programmable period, either forever
// or for a fixed number of pulses, under start/pause/abort control.
// Optional feature macro: CNTR_TICK_GEN_SYNC_EN. When defined, start and stop
// are treated as asynchronous levels: each is synchronized and edge-detected,
// which adds three cycles of latency.

module cntr_tick_gen #(
    parameter int PRESCALE_WIDTH = 8,
    parameter int LIMIT_WIDTH    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      oneshot,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic [LIMIT_WIDTH-1:0]    limit,
    output logic                      en,
    output logic                      busy,
    output logic                      done,
    output logic [LIMIT_WIDTH-1:0]    tick_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                      r_state;
    state_t                      w_nextState;
    logic [PRESCALE_WIDTH-1:0]   r_presc;
    logic [PRESCALE_WIDTH-1:0]   r_prescLatch;
    logic [LIMIT_WIDTH-1:0]      r_limitLatch;
    logic                        r_oneshotLatch;
    logic                        r_en;
    logic [LIMIT_WIDTH-1:0]      r_tickCnt;
    logic                        w_start;
    logic                        w_stop;
    logic                        w_issue;
    logic                        w_lastPulse;
    logic                        w_runBegin;

`ifdef CNTR_TICK_GEN_SYNC_EN
    logic [2:0] r_startSync;
    logic [2:0] r_stopSync;
    logic       r_startPulse;
    logic       r_stopPulse;

    // Two-flop synchronizers plus registered rising-edge detectors on the requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_startSync  <= '0;
            r_stopSync   <= '0;
            r_startPulse <= 1'b0;
            r_stopPulse  <= 1'b0;
        end else begin
            r_startSync  <= {r_startSync[1:0], start};
            r_stopSync   <= {r_stopSync[1:0], stop};
            r_startPulse <= r_startSync[1] & ~r_startSync[2];
            r_stopPulse  <= r_stopSync[1] & ~r_stopSync[2];
        end
    end

    assign w_start = r_startPulse;
    assign w_stop  = r_stopPulse;
`else
    assign w_start = start;
    assign w_stop  = stop;
`endif

    // The one-shot run is complete when the pulse now on en brings the count to the
    // latched limit; a limit of 0 naturally means a full wrap of the counter.
    assign w_lastPulse = r_en & r_oneshotLatch & (r_tickCnt == r_limitLatch);

    // Next-state logic; completion outranks a pause so a finished run never stalls in HOLD.
    always_comb begin
        w_nextState = r_state;
        w_issue     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start && !w_stop) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (w_lastPulse) begin
                    w_nextState = DONE;
                end else if (w_stop) begin
                    w_nextState = HOLD;
                end else begin
                    w_issue = (r_presc == '0);
                end
            end
            HOLD: begin
                if (w_stop) begin
                    w_nextState = IDLE;
                end else if (w_start) begin
                    w_nextState = RUN;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign w_runBegin = (r_state == IDLE) && (w_nextState == RUN);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Run configuration is captured only when a run begins from IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prescLatch   <= '0;
            r_limitLatch   <= '0;
            r_oneshotLatch <= 1'b0;
        end else if (w_runBegin) begin
            r_prescLatch   <= prescale;
            r_limitLatch   <= limit;
            r_oneshotLatch <= oneshot;
        end
    end

    // Prescaler: load on run begin, reload on each pulse, count down while running, else freeze.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_runBegin) begin
            r_presc <= prescale;
        end else if (w_issue) begin
            r_presc <= r_prescLatch;
        end else if ((r_state == RUN) && (w_nextState == RUN)) begin
            r_presc <= r_presc - 1'b1;
        end
    end

    // Enable pulse and pulse counter advance together so tick_cnt matches en in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en      <= 1'b0;
            r_tickCnt <= '0;
        end else begin
            r_en <= w_issue;
            if (w_runBegin) begin
                r_tickCnt <= '0;
            end else if (w_issue) begin
                r_tickCnt <= r_tickCnt + 1'b1;
            end
        end
    end

    assign en       = r_en;
    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign tick_cnt = r_tickCnt;

endmodule
